// File: rtl/arm_alu_pipe.sv
// arm_alu_pipe: two-stage ARM data-processing ALU (16 DP opcodes) with internal NZCV; optional sticky Q via ALU_STICKY_Q_EN.
// Latency: op accepted at edge k is on the output after edge k+1; one op per cycle sustained.
// Backpressure: outReady low holds the output stage, the issue stage still fills, inReady drops with two ops buffered.
module arm_alu_pipe #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       opCode,
    input  logic             setFlags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flagsLoad,
    input  logic [3:0]       flagsIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             outWrite,
    output logic [3:0]       flags
`ifdef ALU_STICKY_Q_EN
    ,
    input  logic             qClear,
    output logic             qFlag
`endif
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    logic             r_s0_vld;
    logic [3:0]       r_s0_op;
    logic             r_s0_s;
    logic [WIDTH-1:0] r_s0_a;
    logic [WIDTH-1:0] r_s0_b;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_res;
    logic             r_s1_wr;
    logic [3:0]       r_nzcv;

    logic             w_adv;
    logic             w_acc;
    logic             w_is_test;
    logic             w_eff_s;
    logic             w_arith;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_adv   = r_s0_vld & (~r_s1_vld | outReady);
    assign inReady = ~r_s0_vld | w_adv;
    assign w_acc   = inValid & inReady;

    // TST/TEQ/CMP/CMN share the 10xx encoding: always set flags, never write back.
    assign w_is_test = (r_s0_op[3:2] == 2'b10);
    assign w_eff_s   = r_s0_s | w_is_test;

    // Every arithmetic op is folded onto x + y + cin; subtraction uses y = ~operand.
    always_comb begin
        w_x     = '0;
        w_y     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (r_s0_op)
            OP_SUB, OP_CMP: begin w_x = r_s0_a; w_y = ~r_s0_b; w_cin = 1'b1;      end
            OP_RSB:         begin w_x = r_s0_b; w_y = ~r_s0_a; w_cin = 1'b1;      end
            OP_ADD, OP_CMN: begin w_x = r_s0_a; w_y = r_s0_b;  w_cin = 1'b0;      end
            OP_ADC:         begin w_x = r_s0_a; w_y = r_s0_b;  w_cin = r_nzcv[1]; end
            OP_SBC:         begin w_x = r_s0_a; w_y = ~r_s0_b; w_cin = r_nzcv[1]; end
            OP_RSC:         begin w_x = r_s0_b; w_y = ~r_s0_a; w_cin = r_nzcv[1]; end
            default:        w_arith = 1'b0;
        endcase
    end

    always_comb begin
        w_logic = '0;
        case (r_s0_op)
            OP_AND, OP_TST: w_logic = r_s0_a & r_s0_b;
            OP_EOR, OP_TEQ: w_logic = r_s0_a ^ r_s0_b;
            OP_ORR:         w_logic = r_s0_a | r_s0_b;
            OP_MOV:         w_logic = r_s0_b;
            OP_BIC:         w_logic = r_s0_a & ~r_s0_b;
            OP_MVN:         w_logic = ~r_s0_b;
            default:        w_logic = '0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
    assign w_n   = w_res[WIDTH-1];
    assign w_z   = ~|w_res;
    // Logical ops leave C and V untouched.
    assign w_c   = w_arith ? w_sum[WIDTH] : r_nzcv[1];
    assign w_v   = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_res[WIDTH-1] != w_x[WIDTH-1]))
                           : r_nzcv[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_vld <= 1'b0;
            r_s0_op  <= '0;
            r_s0_s   <= 1'b0;
            r_s0_a   <= '0;
            r_s0_b   <= '0;
        end else begin
            if (w_acc) begin
                r_s0_vld <= 1'b1;
                r_s0_op  <= opCode;
                r_s0_s   <= setFlags;
                r_s0_a   <= a;
                r_s0_b   <= b;
            end else if (w_adv) begin
                r_s0_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_res <= '0;
            r_s1_wr  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s1_vld <= 1'b1;
                r_s1_res <= w_res;
                r_s1_wr  <= ~w_is_test;
            end else if (outReady) begin
                r_s1_vld <= 1'b0;
            end
        end
    end

    // An MSR-style load overrides all four bits even when an op sets flags on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nzcv <= FLAG_RESET;
        end else if (flagsLoad) begin
            r_nzcv <= flagsIn;
        end else if (w_adv & w_eff_s) begin
            r_nzcv <= {w_n, w_z, w_c, w_v};
        end
    end

`ifdef ALU_STICKY_Q_EN
    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (w_adv & w_eff_s & w_arith & w_v) begin
            r_q <= 1'b1;
        end else if (qClear) begin
            r_q <= 1'b0;
        end
    end

    assign qFlag = r_q;
`endif

    assign outValid = r_s1_vld;
    assign result   = r_s1_res;
    assign outWrite = r_s1_wr;
    assign flags    = r_nzcv;

endmodule

// File: tb/tb_arm_alu_pipe.sv
// Bench for arm_alu_pipe (WIDTH=32): directed literal cases plus randomized traffic against a queue-based model.
module tb_arm_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  opCode;
    logic        setFlags;
    logic [31:0] a;
    logic [31:0] b;
    logic        flagsLoad;
    logic [3:0]  flagsIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        outWrite;
    logic [3:0]  flags;
`ifdef ALU_STICKY_Q_EN
    logic        qClear;
    logic        qFlag;
`endif

    arm_alu_pipe #(.WIDTH(32), .FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .opCode(opCode), .setFlags(setFlags), .a(a), .b(b),
        .flagsLoad(flagsLoad), .flagsIn(flagsIn), .outValid(outValid),
        .outReady(outReady), .result(result), .outWrite(outWrite), .flags(flags)
`ifdef ALU_STICKY_Q_EN
        , .qClear(qClear), .qFlag(qFlag)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;
    typedef struct packed {
        logic [31:0] r;
        logic        w;
    } res_t;

    op_t        pend[$];
    res_t       done[$];
    logic [3:0] mflags = 4'b0000;

    // Architectural result via plain signed/unsigned 64-bit arithmetic.
    function automatic void model_exec(input op_t o, input logic [3:0] f,
                                       output logic [31:0] r, output logic w, output logic [3:0] nf);
        longint ux, uy, us, sx, sy, ss;
        int     si;
        int     ci;
        bit     arith;
        bit     sub;
        logic   c;
        logic   v;
        c = f[1];
        v = f[0];
        arith = 1'b1;
        sub = 1'b0;
        ci = 0;
        ux = 0; uy = 0; sx = 0; sy = 0;
        r = 32'h0;
        case (o.op)
            4'h2, 4'hA: begin sub = 1; ux = o.a; uy = o.b; sx = $signed(o.a); sy = $signed(o.b); ci = 0; end
            4'h3:       begin sub = 1; ux = o.b; uy = o.a; sx = $signed(o.b); sy = $signed(o.a); ci = 0; end
            4'h6:       begin sub = 1; ux = o.a; uy = o.b; sx = $signed(o.a); sy = $signed(o.b); ci = f[1] ? 0 : 1; end
            4'h7:       begin sub = 1; ux = o.b; uy = o.a; sx = $signed(o.b); sy = $signed(o.a); ci = f[1] ? 0 : 1; end
            4'h4, 4'hB: begin ux = o.a; uy = o.b; sx = $signed(o.a); sy = $signed(o.b); ci = 0; end
            4'h5:       begin ux = o.a; uy = o.b; sx = $signed(o.a); sy = $signed(o.b); ci = f[1] ? 1 : 0; end
            default: begin
                arith = 1'b0;
                case (o.op)
                    4'h0, 4'h8: r = o.a & o.b;
                    4'h1, 4'h9: r = o.a ^ o.b;
                    4'hC:       r = o.a | o.b;
                    4'hD:       r = o.b;
                    4'hE:       r = o.a & ~o.b;
                    default:    r = ~o.b;
                endcase
            end
        endcase
        if (arith) begin
            if (sub) begin
                us = ux - uy - ci;
                ss = sx - sy - ci;
                c  = (ux >= uy + ci);
            end else begin
                us = ux + uy + ci;
                ss = sx + sy + ci;
                c  = us[32];
            end
            r  = us[31:0];
            si = r;
            v  = (ss != longint'(si));
        end
        w  = (o.op[3:2] != 2'b10);
        nf = {r[31], (r == 32'h0), c, v};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            done.delete();
            mflags = 4'b0000;
        end else begin
            op_t        o;
            res_t       rr;
            logic [3:0] nf;
            bit         adv;
            adv = (pend.size() > 0) && ((done.size() == 0) || outReady);
            if ((done.size() > 0) && outReady)
                void'(done.pop_front());
            if (adv) begin
                o = pend.pop_front();
                model_exec(o, mflags, rr.r, rr.w, nf);
                done.push_back(rr);
                if (o.s || (o.op[3:2] == 2'b10))
                    mflags = nf;
            end
            if (flagsLoad)
                mflags = flagsIn;
            if (inValid && inReady)
                pend.push_back('{op: opCode, s: setFlags, a: a, b: b});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("outValid", {31'b0, outValid}, {31'b0, done.size() > 0});
            chk("inReady", {31'b0, inReady},
                {31'b0, (pend.size() == 0) || (done.size() == 0) || outReady});
            chk("flags", {28'b0, flags}, {28'b0, mflags});
            if (done.size() > 0) begin
                chk("result", result, done[0].r);
                chk("outWrite", {31'b0, outWrite}, {31'b0, done[0].w});
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Called in the phase just after a rising edge; returns in that phase after acceptance.
    task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] xa, input logic [31:0] xb);
        bit ok;
        ok = 0;
        inValid = 1'b1; opCode = op; setFlags = s; a = xa; b = xb;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = inReady;
            @(posedge clk); #2;
            if (ok) break;
        end
        inValid = 1'b0;
        chk("issue_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_out(input string nm, input logic [31:0] er, input logic ew,
                            input logic [3:0] ef, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (outValid) break;
        end
        chk({nm, "_valid"}, {31'b0, outValid}, 32'd1);
        chk({nm, "_res"}, result, er);
        chk({nm, "_wr"}, {31'b0, outWrite}, {31'b0, ew});
        chk({nm, "_flags"}, {28'b0, flags}, {28'b0, ef});
        @(posedge clk); #2;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        bit rdy;
        reset = 1'b1; inValid = 1'b0; opCode = 4'h0; setFlags = 1'b0; a = '0; b = '0;
        flagsLoad = 1'b0; flagsIn = 4'h0; outReady = 1'b1;
`ifdef ALU_STICKY_Q_EN
        qClear = 1'b0;
`endif
        #12;
        chk("rst_outValid", {31'b0, outValid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_outWrite", {31'b0, outWrite}, 32'd0);
        chk("rst_flags", {28'b0, flags}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_inReady", {31'b0, inReady}, 32'd1);
        @(posedge clk); #2;

        // ADD S overflow into the sign bit; result visible one edge after accept
        issue(4'h4, 1, 32'h7FFF_FFFF, 32'h1);
        wait_out("add_ovf", 32'h8000_0000, 1, 4'b1001, n);
        chk("add_latency", n, 32'd2);

        issue(4'h2, 1, 32'd5, 32'd5);
        wait_out("sub_eq", 32'h0, 1, 4'b0110, n);
        issue(4'hA, 0, 32'd3, 32'd5);
        wait_out("cmp", 32'hFFFF_FFFE, 0, 4'b1000, n);
        issue(4'h6, 1, 32'd5, 32'd3);
        wait_out("sbc", 32'h1, 1, 4'b0010, n);

        // back-to-back: ADC must see the carry produced by the ADD just ahead of it
        issue(4'h4, 1, 32'hFFFF_FFFF, 32'h1);
        issue(4'h5, 0, 32'h0, 32'h0);
        wait_out("b2b_add", 32'h0, 1, 4'b0110, n);
        wait_out("b2b_adc", 32'h1, 1, 4'b0110, n);

        // consumer stall with a continuous offer
        outReady = 1'b0; inValid = 1'b1; opCode = 4'h4; setFlags = 1'b0; a = 32'd0; b = 32'd100;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy = inReady;
            if (rdy) acc++;
            @(posedge clk); #2;
            if (rdy) a = a + 1;
        end
        inValid = 1'b0;
        @(negedge clk);
        chk("stall_accepts", acc, 32'd2);
        chk("stall_inReady", {31'b0, inReady}, 32'd0);
        @(posedge clk); #2;
        outReady = 1'b1;
        wait_out("drain0", 32'd100, 1, 4'b0110, n);
        wait_out("drain1", 32'd101, 1, 4'b0110, n);

        // flag load coincides with a flag-setting execute and wins
        issue(4'h2, 1, 32'd5, 32'd5);
        flagsLoad = 1'b1; flagsIn = 4'b1111;
        @(posedge clk); #2;
        flagsLoad = 1'b0;
        wait_out("fload", 32'h0, 1, 4'b1111, n);
        issue(4'h0, 1, 32'h1, 32'h1);
        wait_out("and_keep_cv", 32'h1, 1, 4'b0011, n);

        // reset with two ops in flight
        outReady = 1'b0;
        issue(4'h4, 0, 32'd1, 32'd1);
        issue(4'h4, 0, 32'd2, 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("midrst_outValid", {31'b0, outValid}, 32'd0);
        chk("midrst_flags", {28'b0, flags}, 32'd0);
        chk("midrst_result", result, 32'h0);
        #2 reset = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", {31'b0, outValid}, 32'd0);
        end
        @(posedge clk); #2;

`ifdef ALU_STICKY_Q_EN
        issue(4'h4, 1, 32'h7FFF_FFFF, 32'h1);
        wait_out("q_set", 32'h8000_0000, 1, 4'b1001, n);
        chk("qflag_set", {31'b0, qFlag}, 32'd1);
        issue(4'h4, 1, 32'd1, 32'd1);
        wait_out("q_keep", 32'd2, 1, 4'b0000, n);
        chk("qflag_keep", {31'b0, qFlag}, 32'd1);
        qClear = 1'b1;
        @(posedge clk); #2;
        qClear = 1'b0;
        @(negedge clk);
        chk("qflag_clear", {31'b0, qFlag}, 32'd0);
        @(posedge clk); #2;
`endif

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 1000; i++) begin
            inValid   = ($urandom_range(0, 9) < 7);
            opCode    = 4'($urandom_range(0, 15));
            setFlags  = 1'($urandom_range(0, 1));
            a         = pick();
            b         = pick();
            outReady  = ($urandom_range(0, 9) < 7);
            flagsLoad = ($urandom_range(0, 19) == 0);
            flagsIn   = 4'($urandom_range(0, 15));
            @(posedge clk); #2;
        end
        inValid = 1'b0; flagsLoad = 1'b0; outReady = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("drained", 32'(pend.size() + done.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
